// File: rtl/fetch_pkg.sv
// Shared types and default sizing for the instruction fetch block.
package fetch_pkg;

  localparam int unsigned AddrWDefault    = 5;
  localparam int unsigned DataWDefault    = 8;
  localparam logic [7:0]  HaltCodeDefault = 8'hFF;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StHold  = 2'd2,
    StHalt  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/pc_counter.sv
// Program counter: synchronous active-low reset, load beats increment, wraps at 2^Width.
module pc_counter #(
  parameter int unsigned Width = 5
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             inc_i,
  output logic [Width-1:0] pc_o
);

  logic [Width-1:0] pc_d, pc_q;

  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = load_val_i;
    end else if (inc_i) begin
      pc_d = pc_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/instruction_fetch.sv
// Byte-wide instruction fetcher: requests program bytes, hands them downstream with a
// valid/ready handshake, and stops on the halt opcode until reloaded.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W    = AddrWDefault,
  parameter int unsigned       DATA_W    = DataWDefault,
  parameter logic [DATA_W-1:0] HALT_CODE = DATA_W'(HaltCodeDefault)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              load_pc,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  input  logic              data_ready,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);

  fetch_state_e      state_q;
  logic [DATA_W-1:0] data_q;
  logic              fetch_ack;
  logic              is_halt;
  logic              pc_inc;

  assign fetch_ack = (state_q == StFetch) && mem_ack;
  assign is_halt   = (mem_data == HALT_CODE);
  // The counter gives load priority, so a coincident load_pc discards this increment.
  assign pc_inc    = fetch_ack && !is_halt;

  pc_counter #(
    .Width(ADDR_W)
  ) u_pc_counter (
    .clk_i     (clock),
    .rst_ni    (reset),
    .load_i    (load_pc),
    .load_val_i(pc_in),
    .inc_i     (pc_inc),
    .pc_o      (pc)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= StIdle;
      data_q  <= '0;
    end else if (load_pc) begin
      state_q <= StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (enable) state_q <= StFetch;
        end
        // An outstanding request completes even if enable drops meanwhile.
        StFetch: begin
          if (mem_ack) begin
            if (is_halt) begin
              state_q <= StHalt;
            end else begin
              data_q  <= mem_data;
              state_q <= StHold;
            end
          end
        end
        StHold: begin
          if (data_ready) state_q <= enable ? StFetch : StIdle;
        end
        StHalt: begin
          state_q <= StHalt;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign mem_req    = (state_q == StFetch);
  assign data_valid = (state_q == StHold);
  assign halted     = (state_q == StHalt);
  assign mem_addr   = pc;
  assign data_out   = data_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed vector table plus randomized traffic checked against a behavioural fetch model.
module tb_instruction_fetch;

  logic       clock = 1'b0;
  logic       reset, enable, load_pc, mem_ack, data_ready;
  logic [4:0] pc_in;
  logic [7:0] mem_data;
  logic       mem_req, data_valid, halted;
  logic [4:0] mem_addr, pc;
  logic [7:0] data_out;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  instruction_fetch dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .load_pc   (load_pc),
    .pc_in     (pc_in),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_data  (mem_data),
    .data_out  (data_out),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .pc        (pc),
    .halted    (halted)
  );

  // Behavioural model: pending request, byte on offer, halted flag, counter.
  int m_pc;
  int m_byte;
  bit m_waiting, m_have, m_halted;

  task automatic model_step();
    if (!reset) begin
      m_pc = 0; m_byte = 0; m_waiting = 0; m_have = 0; m_halted = 0;
    end else if (load_pc) begin
      m_pc = int'(pc_in); m_waiting = 0; m_have = 0; m_halted = 0;
    end else if (m_halted) begin
      // frozen until reload or reset
    end else if (m_have) begin
      if (data_ready) begin
        m_have = 0;
        m_waiting = enable;
      end
    end else if (m_waiting) begin
      if (mem_ack) begin
        m_waiting = 0;
        if (mem_data == 8'hFF) begin
          m_halted = 1;
        end else begin
          m_byte = int'(mem_data);
          m_have = 1;
          m_pc = (m_pc + 1) % 32;
        end
      end
    end else if (enable) begin
      m_waiting = 1;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic       rst;
    logic       en;
    logic       ld;
    logic [4:0] pcin;
    logic       ack;
    logic [7:0] md;
    logic       rdy;
    logic       e_req;
    logic       e_valid;
    logic       e_halt;
    logic [4:0] e_pc;
    logic [7:0] e_dout;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, input logic en, input logic ld,
                              input logic [4:0] pcin, input logic ack, input logic [7:0] md,
                              input logic rdy, input logic e_req, input logic e_valid,
                              input logic e_halt, input logic [4:0] e_pc,
                              input logic [7:0] e_dout);
    vec_t v;
    v = '{rst, en, ld, pcin, ack, md, rdy, e_req, e_valid, e_halt, e_pc, e_dout};
    return v;
  endfunction

  task automatic apply(input vec_t v);
    reset = v.rst; enable = v.en; load_pc = v.ld; pc_in = v.pcin;
    mem_ack = v.ack; mem_data = v.md; data_ready = v.rdy;
  endtask

  task automatic check_model(input string tag);
    chk({tag, " mem_req"},    int'(mem_req),    int'(m_waiting));
    chk({tag, " data_valid"}, int'(data_valid), int'(m_have));
    chk({tag, " halted"},     int'(halted),     int'(m_halted));
    chk({tag, " pc"},         int'(pc),         m_pc);
    chk({tag, " mem_addr"},   int'(mem_addr),   m_pc);
    chk({tag, " data_out"},   int'(data_out),   m_byte);
  endtask

  initial begin
    reset = 0; enable = 0; load_pc = 0; pc_in = '0;
    mem_ack = 0; mem_data = '0; data_ready = 0;

    //        rst en ld pcin ack md     rdy | req val hlt pc  dout
    vecs.push_back(mk(0, 0, 0, 5'd0,  0, 8'h00, 0, 0, 0, 0, 5'd0,  8'h00)); // reset
    vecs.push_back(mk(1, 1, 0, 5'd0,  0, 8'h00, 0, 1, 0, 0, 5'd0,  8'h00)); // fetch @0
    vecs.push_back(mk(1, 1, 0, 5'd0,  1, 8'h0B, 0, 0, 1, 0, 5'd1,  8'h0B));
    vecs.push_back(mk(1, 1, 0, 5'd0,  0, 8'h00, 1, 1, 0, 0, 5'd1,  8'h0B));
    vecs.push_back(mk(1, 1, 0, 5'd0,  1, 8'h09, 0, 0, 1, 0, 5'd2,  8'h09));
    vecs.push_back(mk(1, 1, 0, 5'd0,  0, 8'h00, 1, 1, 0, 0, 5'd2,  8'h09));
    vecs.push_back(mk(1, 1, 0, 5'd0,  1, 8'h0D, 0, 0, 1, 0, 5'd3,  8'h0D));
    vecs.push_back(mk(1, 1, 0, 5'd0,  0, 8'h00, 1, 1, 0, 0, 5'd3,  8'h0D));
    vecs.push_back(mk(1, 1, 0, 5'd0,  1, 8'h06, 0, 0, 1, 0, 5'd4,  8'h06)); // stall 4 cycles
    vecs.push_back(mk(1, 1, 0, 5'd0,  0, 8'h00, 0, 0, 1, 0, 5'd4,  8'h06));
    vecs.push_back(mk(1, 1, 0, 5'd0,  1, 8'h55, 0, 0, 1, 0, 5'd4,  8'h06));
    vecs.push_back(mk(1, 1, 0, 5'd0,  0, 8'h00, 0, 0, 1, 0, 5'd4,  8'h06));
    vecs.push_back(mk(1, 1, 0, 5'd0,  0, 8'h00, 0, 0, 1, 0, 5'd4,  8'h06));
    vecs.push_back(mk(1, 0, 0, 5'd0,  0, 8'h00, 1, 0, 0, 0, 5'd4,  8'h06)); // to idle
    vecs.push_back(mk(1, 0, 1, 5'd31, 0, 8'h00, 0, 0, 0, 0, 5'd31, 8'h06)); // load 31
    vecs.push_back(mk(1, 1, 0, 5'd0,  0, 8'h00, 0, 1, 0, 0, 5'd31, 8'h06));
    vecs.push_back(mk(1, 0, 0, 5'd0,  0, 8'h00, 0, 1, 0, 0, 5'd31, 8'h06)); // enable drop
    vecs.push_back(mk(1, 0, 0, 5'd0,  1, 8'h07, 0, 0, 1, 0, 5'd0,  8'h07)); // wrap
    vecs.push_back(mk(1, 1, 0, 5'd0,  0, 8'h00, 1, 1, 0, 0, 5'd0,  8'h07));
    vecs.push_back(mk(1, 1, 1, 5'd9,  1, 8'h0A, 0, 0, 0, 0, 5'd9,  8'h07)); // load beats ack
    vecs.push_back(mk(1, 1, 0, 5'd0,  0, 8'h00, 0, 1, 0, 0, 5'd9,  8'h07));
    vecs.push_back(mk(1, 1, 0, 5'd0,  1, 8'hFF, 0, 0, 0, 1, 5'd9,  8'h07)); // halt
    vecs.push_back(mk(1, 1, 0, 5'd0,  1, 8'h12, 1, 0, 0, 1, 5'd9,  8'h07));
    vecs.push_back(mk(1, 1, 0, 5'd0,  1, 8'h12, 1, 0, 0, 1, 5'd9,  8'h07));
    vecs.push_back(mk(1, 0, 1, 5'd2,  0, 8'h00, 0, 0, 0, 0, 5'd2,  8'h07)); // reload exits
    vecs.push_back(mk(1, 1, 0, 5'd0,  0, 8'h00, 0, 1, 0, 0, 5'd2,  8'h07));
    vecs.push_back(mk(1, 1, 0, 5'd0,  1, 8'h0E, 0, 0, 1, 0, 5'd3,  8'h0E));
    vecs.push_back(mk(0, 1, 0, 5'd0,  0, 8'h00, 0, 0, 0, 0, 5'd0,  8'h00)); // reset in hold
    vecs.push_back(mk(0, 1, 1, 5'd5,  1, 8'h33, 1, 0, 0, 0, 5'd0,  8'h00)); // reset beats load
    vecs.push_back(mk(1, 0, 0, 5'd0,  0, 8'h00, 0, 0, 0, 0, 5'd0,  8'h00));

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i]);
      @(posedge clock);
      model_step();
      #1;
      chk($sformatf("vec%0d mem_req", i),    int'(mem_req),    int'(vecs[i].e_req));
      chk($sformatf("vec%0d data_valid", i), int'(data_valid), int'(vecs[i].e_valid));
      chk($sformatf("vec%0d halted", i),     int'(halted),     int'(vecs[i].e_halt));
      chk($sformatf("vec%0d pc", i),         int'(pc),         int'(vecs[i].e_pc));
      chk($sformatf("vec%0d mem_addr", i),   int'(mem_addr),   int'(vecs[i].e_pc));
      chk($sformatf("vec%0d data_out", i),   int'(data_out),   int'(vecs[i].e_dout));
    end

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      reset      = ($urandom_range(63) != 0);
      load_pc    = ($urandom_range(15) == 0);
      pc_in      = 5'($urandom_range(31));
      enable     = ($urandom_range(3) != 0);
      mem_ack    = $urandom_range(1) == 1;
      mem_data   = ($urandom_range(9) == 0) ? 8'hFF : 8'($urandom_range(254));
      data_ready = $urandom_range(1) == 1;
      @(posedge clock);
      model_step();
      #1;
      check_model($sformatf("rand%0d", c));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
